// File: rtl/uff_pkg.sv
// Shared mode encoding for the universal flip-flop bank.
package uff_pkg;

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    typedef enum logic [1:0] {
        UFF_D  = MODE_D,
        UFF_T  = MODE_T,
        UFF_JK = MODE_JK,
        UFF_SR = MODE_SR
    } uff_mode_t;

endpackage

// File: rtl/uff_bit_cell.sv
// One bit of the flip-flop bank: next-state logic plus the illegal-SR strobe.
// Purely combinational; the register itself lives in the top.
import uff_pkg::*;

module uff_bit_cell (
    input  uff_mode_t i_mode,
    input  logic      i_q,
    input  logic      i_a,
    input  logic      i_b,
    output logic      o_nxt,
    output logic      o_illegal
);

    // Select the next state for the active flip-flop personality.
    always_comb begin
        o_nxt     = i_q;
        o_illegal = 1'b0;
        case (i_mode)
            UFF_D:  o_nxt = i_a;
            UFF_T:  o_nxt = i_q ^ i_a;
            UFF_JK: begin
                case ({i_a, i_b})
                    2'b01:   o_nxt = 1'b0;
                    2'b10:   o_nxt = 1'b1;
                    2'b11:   o_nxt = ~i_q;
                    default: o_nxt = i_q;
                endcase
            end
            UFF_SR: begin
                case ({i_a, i_b})
                    2'b01:   o_nxt = 1'b0;
                    2'b10:   o_nxt = 1'b1;
                    // s=r=1 holds the bit and raises the strobe.
                    2'b11:   o_illegal = 1'b1;
                    default: o_nxt = i_q;
                endcase
            end
            default: o_nxt = i_q;
        endcase
    end

endmodule

// File: rtl/universal_ff_bank.sv
// WIDTH-bit register bank whose bits act as D/T/JK/SR flip-flops, selected
// per cycle by mode. Priority rst > load > en > hold. Illegal SR (s=r=1)
// holds the bit and sets a sticky per-bit error flag.
// Optional: define UFF_ILLEGAL_CNT_EN to add a saturating err_cnt output that
// counts cycles containing at least one illegal SR bit.
import uff_pkg::*;

module universal_ff_bank #(
    parameter int             WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int             CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] err_flags,
    output logic             err_any
`ifdef UFF_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_err;
    logic             r_err_any;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_ill_raw;
    logic [WIDTH-1:0] w_ill;
    logic [WIDTH-1:0] w_err_next;
    logic             w_upd;
    uff_mode_t        w_mode;

    // A zero-width counter is meaningless even when the counter is built out.
    if (CNT_W < 1) begin : g_bad_cnt_w
    end

    assign w_mode = uff_mode_t'(mode);
    assign w_upd  = en & ~load;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        uff_bit_cell u_cell (
            .i_mode    (w_mode),
            .i_q       (r_q[gi]),
            .i_a       (a[gi]),
            .i_b       (b[gi]),
            .o_nxt     (w_nxt[gi]),
            .o_illegal (w_ill_raw[gi])
        );
    end

    // Errors only count when the mode logic actually drives the update.
    assign w_ill      = w_ill_raw & {WIDTH{w_upd}};
    assign w_err_next = (clr_err ? {WIDTH{1'b0}} : r_err) | w_ill;

    // State register: load beats enable; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= RESET_VAL;
        else if (load)
            r_q <= din;
        else if (en)
            r_q <= w_nxt;
    end

    // Sticky error flags; a new event on the clearing edge survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err     <= '0;
            r_err_any <= 1'b0;
        end else begin
            r_err     <= w_err_next;
            r_err_any <= |w_err_next;
        end
    end

`ifdef UFF_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             w_ill_any;

    assign w_ill_any = |w_ill;

    // One count per cycle with any illegal bit, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (clr_err)
            r_cnt <= CNT_W'(w_ill_any);
        else if (w_ill_any && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign err_cnt = r_cnt;
`endif

    assign q         = r_q;
    assign qbar      = ~r_q;
    assign err_flags = r_err;
    assign err_any   = r_err_any;

endmodule

// File: tb/tb_universal_ff_bank.sv
// Directed bench for universal_ff_bank (WIDTH=8, CNT_W=8).
// Define UFF_ILLEGAL_CNT_EN for both files to exercise the counter output.
module tb_universal_ff_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       en;
    logic       load;
    logic [7:0] din;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr_err;
    logic [7:0] q;
    logic [7:0] qbar;
    logic [7:0] err_flags;
    logic       err_any;
`ifdef UFF_ILLEGAL_CNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    universal_ff_bank #(
        .WIDTH     (8),
        .RESET_VAL (8'h00),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .en        (en),
        .load      (load),
        .din       (din),
        .a         (a),
        .b         (b),
        .clr_err   (clr_err),
        .q         (q),
        .qbar      (qbar),
        .err_flags (err_flags),
        .err_any   (err_any)
`ifdef UFF_ILLEGAL_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; en = 1'b0; load = 1'b0;
        din = 8'h00; a = 8'h00; b = 8'h00; clr_err = 1'b0;
        tick(); tick();
        chk("reset_q", {24'd0, q}, 32'h00);
        chk("reset_qbar", {24'd0, qbar}, 32'hFF);
        chk("reset_err", {24'd0, err_flags}, 32'h00);
        chk("reset_err_any", {31'd0, err_any}, 32'd0);

        // Load A5, then assert reset between edges.
        rst = 1'b0; load = 1'b1; din = 8'hA5;
        tick();
        chk("load_a5", {24'd0, q}, 32'hA5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q", {24'd0, q}, 32'h00);
        chk("async_rst_qbar", {24'd0, qbar}, 32'hFF);
        chk("async_rst_err_any", {31'd0, err_any}, 32'd0);
        tick();
        chk("rst_over_load", {24'd0, q}, 32'h00);
        rst = 1'b0; load = 1'b0;

        // D then T.
        en = 1'b1; mode = 2'b00; a = 8'h3C;
        tick();
        chk("d_mode", {24'd0, q}, 32'h3C);
        mode = 2'b01; a = 8'h0F;
        tick();
        chk("t_mode", {24'd0, q}, 32'h33);

        // JK set/clear then toggle.
        mode = 2'b10; a = 8'hF0; b = 8'h0F;
        tick();
        chk("jk_set_clr", {24'd0, q}, 32'hF0);
        a = 8'hFF; b = 8'hFF;
        tick();
        chk("jk_toggle", {24'd0, q}, 32'h0F);
        chk("jk_qbar", {24'd0, qbar}, 32'hF0);

        // SR with an illegal bit 0.
        mode = 2'b11; a = 8'h81; b = 8'h01;
        tick();
        chk("sr_q", {24'd0, q}, 32'h8F);
        chk("sr_err", {24'd0, err_flags}, 32'h01);
        chk("sr_err_any", {31'd0, err_any}, 32'd1);
`ifdef UFF_ILLEGAL_CNT_EN
        chk("sr_cnt", {24'd0, err_cnt}, 32'd1);
`endif

        // Clear on the same edge as a new illegal event.
        clr_err = 1'b1; a = 8'h80; b = 8'h80;
        tick();
        chk("clr_vs_new_q", {24'd0, q}, 32'h8F);
        chk("clr_vs_new_err", {24'd0, err_flags}, 32'h80);
        chk("clr_vs_new_any", {31'd0, err_any}, 32'd1);
`ifdef UFF_ILLEGAL_CNT_EN
        chk("clr_vs_new_cnt", {24'd0, err_cnt}, 32'd1);
`endif

        // Plain clear.
        a = 8'h00; b = 8'h00;
        tick();
        chk("clr_err", {24'd0, err_flags}, 32'h00);
        chk("clr_err_any", {31'd0, err_any}, 32'd0);
        chk("clr_hold_qbar", {24'd0, qbar}, 32'h70);
        clr_err = 1'b0;

        // Load wins; en=0 with illegal SR flags nothing.
        load = 1'b1; din = 8'h5A; en = 1'b0; a = 8'hFF; b = 8'hFF;
        tick();
        chk("load_prio_q", {24'd0, q}, 32'h5A);
        chk("load_prio_err", {24'd0, err_flags}, 32'h00);
        en = 1'b1;
        tick();
        chk("load_en_err", {24'd0, err_flags}, 32'h00);
        load = 1'b0; en = 1'b0;
        tick();
        chk("en0_hold_q", {24'd0, q}, 32'h5A);
        chk("en0_err", {24'd0, err_flags}, 32'h00);
        chk("en0_err_any", {31'd0, err_any}, 32'd0);

        // Sticky flag survives a later legal SR update.
        en = 1'b1; a = 8'h02; b = 8'h02;
        tick();
        chk("sticky_set", {24'd0, err_flags}, 32'h02);
        a = 8'h01; b = 8'h00;
        tick();
        chk("sticky_q", {24'd0, q}, 32'h5B);
        chk("sticky_hold", {24'd0, err_flags}, 32'h02);
        chk("sticky_any", {31'd0, err_any}, 32'd1);

`ifdef UFF_ILLEGAL_CNT_EN
        clr_err = 1'b1; a = 8'h00;
        tick();
        chk("cnt_cleared", {24'd0, err_cnt}, 32'd0);
        clr_err = 1'b0; a = 8'hFF; b = 8'hFF;
        for (int i = 0; i < 300; i++) tick();
        chk("cnt_saturate", {24'd0, err_cnt}, 32'hFF);
        a = 8'h00; b = 8'h00; clr_err = 1'b1;
        tick();
        chk("cnt_clr_after_sat", {24'd0, err_cnt}, 32'd0);
        clr_err = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/universal_ff_bank.md
Name: universal_ff_bank

Overview:
- Parametrised WIDTH-bit register bank, positive-edge triggered.
- Each cycle, a mode input makes all bits behave as D, T, JK or SR flip-flops.
- Successor to the single-bit SR flip-flop: adds asynchronous reset, parallel load, enable, a defined illegal-SR policy and sticky error reporting.
- Building block for counters, control registers and lab sequential exercises.

Parameters:
- WIDTH, 8: number of flip-flop bits.
- RESET_VAL, {WIDTH{1'b0}}: value of q on reset.
- CNT_W, 8: width of the illegal-event counter (used only when the optional feature is enabled).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- mode  input  2  operating mode: D=00, T=01, JK=10, SR=11.
- en  input  1  update enable; when low, q holds.
- load  input  1  synchronous parallel load of din.
- din  input  WIDTH  parallel load data.
- a  input  WIDTH  per-bit input 1: d (D mode), t (T mode), j (JK mode), s (SR mode).
- b  input  WIDTH  per-bit input 2: k (JK mode), r (SR mode); ignored in D and T modes.
- clr_err  input  1  synchronous clear of err_flags and err_any.
- q  output  WIDTH  register state.
- qbar  output  WIDTH  ~q, combinational.
- err_flags  output  WIDTH  sticky per-bit illegal-SR flags.
- err_any  output  1  registered OR of err_flags.

Behaviour:
- Reset: rst high asynchronously forces q=RESET_VAL, err_flags=0, err_any=0 and counter=0. Reset overrides everything, including mid-cycle and during load. The first update occurs on the first rising edge after rst falls.
- Priority at each rising edge: rst > load > en > hold.
- load=1: q<=din. Mode, en, a and b are ignored. No error is flagged.
- load=0, en=1: each bit i updates per mode:
  - D: q[i]<=a[i].
  - T: q[i]<=q[i]^a[i].
  - JK: 00 hold, 01 clear, 10 set, 11 toggle (a=j, b=k).
  - SR: 00 hold, 01 clear, 10 set (a=s, b=r).
  - SR with s=r=1 is illegal: q[i] holds (never X) and err_flags[i] is set.
- load=0, en=0: q holds. No error is flagged, even if a=b=1 in SR mode.
- Latency: one cycle from input to q. qbar tracks q combinationally. err_flags updates on the same edge as the illegal event. err_any lags err_flags by 0 cycles, computed from next-state flags.
- clr_err=1: err_flags<=0, except bits with an illegal event on that same edge, which are set. New events win over the clear.
- Mode may change on any cycle. No state depends on the previous mode.
- No X may propagate from q for any legal input combination.

Optional Feature:
- Macro: UFF_ILLEGAL_CNT_EN.
- Enabled:
  - Adds output err_cnt [CNT_W-1:0].
  - Counts cycles with at least one illegal SR bit (one increment per cycle, regardless of how many bits are illegal).
  - Saturates at all-ones; no wrap.
  - Cleared by rst or clr_err. If clr_err and an illegal event occur on the same edge, the result is 1.
- Disabled: err_cnt port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package uff_pkg holds:
  - Mode constants: MODE_D=2'b00, MODE_T=2'b01, MODE_JK=2'b10, MODE_SR=2'b11.
  - uff_mode_t typedef.
- Sub-module uff_bit_cell is purely combinational.
  - Inputs: mode, q, a, b.
  - Outputs: next-state bit and illegal strobe.
  - Instantiated WIDTH times via generate.
- Top module holds the q register, load/en muxing, error flags and the optional counter.

Test Plan:
- Reset: drive rst=1 mid-stream with q=8'hA5, asynchronously between edges → q=8'h00, qbar=8'hFF and err_any=0 immediately, before any clock edge.
- D/T: D mode with a=8'h3C, en=1 → q=8'h3C next edge. Then T mode with a=8'h0F → q=8'h33.
- JK: from q=8'h33, JK mode with a=8'hF0, b=8'h0F → q=8'hF0. Then a=b=8'hFF → q=8'h0F (toggle).
- Illegal SR: from q=8'h0F, SR mode with a=8'h81, b=8'h01 → q=8'h8F, err_flags=8'h01, err_any=1. With the feature on, err_cnt=1.
- Clear vs new event: clr_err=1 on the same edge as SR a=b=8'h80 → err_flags=8'h80, err_any=1.
- Priority and enable: load=1, din=8'h5A, en=0, SR a=b=8'hFF → q=8'h5A and no error. Then en=0, load=0 → q holds 8'h5A. With the feature on, run 300 illegal cycles at CNT_W=8 → err_cnt=8'hFF.
